// File: rtl/periph_bus_arbiter_pkg.sv
// periph_bus_pkg: shared state encoding, width defaults and the round-robin pick rule
// for periph_bus_arbiter. Revision 1.0.
`default_nettype none

package periph_bus_pkg;

  localparam int DATAWIDTH_DEF = 32;
  localparam int MAX_REQ       = 8;
  localparam int MAX_PTR_W     = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  // First set bit at or above ptr, wrapping at n; scanning offsets downward lets the
  // smallest offset overwrite the result last.
  function automatic logic [MAX_PTR_W-1:0] rr_pick(input logic [MAX_REQ-1:0]   req,
                                                   input logic [MAX_PTR_W-1:0] ptr,
                                                   input int                   n);
    logic [MAX_PTR_W-1:0] win;
    int                   idx;
    win = ptr;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (i < n) begin
        idx = (int'(ptr) + i) % n;
        if (req[idx]) win = idx[MAX_PTR_W-1:0];
      end
    end
    return win;
  endfunction

endpackage

`default_nettype wire

// File: rtl/periph_bus_arbiter_picker.sv
// periph_rr_picker: combinational round-robin priority encoder over NUM_REQ requests.
// Revision 1.0.
`default_nettype none

module periph_rr_picker
  import periph_bus_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [PTR_W-1:0]   grant,
  output logic               any_req
);

  logic [MAX_REQ-1:0]   req_ext;
  logic [MAX_PTR_W-1:0] ptr_ext;
  logic [MAX_PTR_W-1:0] pick;

  always_comb begin
    req_ext                = '0;
    req_ext[NUM_REQ-1:0]   = req;
    ptr_ext                = '0;
    ptr_ext[PTR_W-1:0]     = ptr;
    pick                   = rr_pick(req_ext, ptr_ext, NUM_REQ);
    grant                  = pick[PTR_W-1:0];
    any_req                = |req;
  end

endmodule

`default_nettype wire

// File: rtl/periph_bus_arbiter.sv
// periph_bus_arbiter: round-robin share of one core register port between NUM_REQ masters.
// Optional macro PERIPH_BUS_ARBITER_LOCK_EN adds req_lock for atomic sequences. Revision 1.0.
`default_nettype none

module periph_bus_arbiter
  import periph_bus_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int REGS         = 3,
  parameter int ADDRESSWIDTH = (REGS > 1) ? $clog2(REGS) : 1,
  parameter int DATAWIDTH    = DATAWIDTH_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*ADDRESSWIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATAWIDTH-1:0]   req_wdata,
`ifdef PERIPH_BUS_ARBITER_LOCK_EN
  input  logic [NUM_REQ-1:0]             req_lock,
`endif
  output logic [NUM_REQ-1:0]             ack,
  output logic [NUM_REQ-1:0]             err,
  output logic [DATAWIDTH-1:0]           rdata,
  output logic [DATAWIDTH-1:0]           core_data_in,
  output logic [REGS-1:0]                core_write_en,
  output logic [REGS-1:0]                core_read_en,
  input  logic [REGS*DATAWIDTH-1:0]      core_data_out
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // One extra bit so REGS itself is representable for the range compare.
  localparam logic [ADDRESSWIDTH:0] REGS_LIM = (ADDRESSWIDTH + 1)'(REGS);

  logic [ADDRESSWIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATAWIDTH-1:0]    wdata_arr [NUM_REQ];
  logic [DATAWIDTH-1:0]    dout_arr  [REGS];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req_unpack
    assign addr_arr[g]  = req_addr[g*ADDRESSWIDTH +: ADDRESSWIDTH];
    assign wdata_arr[g] = req_wdata[g*DATAWIDTH +: DATAWIDTH];
  end

  for (genvar g = 0; g < REGS; g++) begin : g_reg_unpack
    assign dout_arr[g] = core_data_out[g*DATAWIDTH +: DATAWIDTH];
  end

  arb_state_t              state_q, state_d;
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]        win_q, win_d;
  logic                    we_q, we_d;
  logic [ADDRESSWIDTH-1:0] addr_q, addr_d;
  logic                    bad_q, bad_d;
  logic [DATAWIDTH-1:0]    rdata_q, rdata_d;
  logic [DATAWIDTH-1:0]    data_in_q, data_in_d;
  logic [NUM_REQ-1:0]      ack_q, ack_d;
  logic [NUM_REQ-1:0]      err_q, err_d;
  logic [REGS-1:0]         wen_q, wen_d;
  logic [REGS-1:0]         ren_q, ren_d;
`ifdef PERIPH_BUS_ARBITER_LOCK_EN
  logic                    lock_q, lock_d;
`endif

  logic [PTR_W-1:0] rr_grant;
  logic             rr_any;
  logic [PTR_W-1:0] sel;
  logic             go;
  logic             addr_ok;

  periph_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req     (req),
    .ptr     (rr_ptr_q),
    .grant   (rr_grant),
    .any_req (rr_any)
  );

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    win_d     = win_q;
    we_d      = we_q;
    addr_d    = addr_q;
    bad_d     = bad_q;
    rdata_d   = rdata_q;
    data_in_d = data_in_q;
    ack_d     = '0;
    err_d     = '0;
    wen_d     = '0;
    ren_d     = '0;
    sel       = '0;
    go        = 1'b0;
    addr_ok   = 1'b0;
`ifdef PERIPH_BUS_ARBITER_LOCK_EN
    lock_d    = lock_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef PERIPH_BUS_ARBITER_LOCK_EN
        if (lock_q && req[win_q] && req_lock[win_q]) begin
          sel = win_q;
          go  = 1'b1;
        end else begin
          lock_d = 1'b0;
          sel    = rr_grant;
          go     = rr_any;
        end
`else
        sel = rr_grant;
        go  = rr_any;
`endif
        if (go) begin
          win_d     = sel;
          we_d      = req_we[sel];
          addr_d    = addr_arr[sel];
          data_in_d = wdata_arr[sel];
          addr_ok   = {1'b0, addr_arr[sel]} < REGS_LIM;
          bad_d     = !addr_ok;
          // Strobes are registered here so they are high exactly during ACCESS.
          for (int r = 0; r < REGS; r++) begin
            if (addr_ok && (addr_arr[sel] == r[ADDRESSWIDTH-1:0])) begin
              wen_d[r] = req_we[sel];
              ren_d[r] = !req_we[sel];
            end
          end
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (bad_q)      rdata_d = '0;
        else if (!we_q) rdata_d = dout_arr[addr_q];
        ack_d[win_q] = 1'b1;
        err_d[win_q] = bad_q;
        state_d      = DONE;
      end
      DONE: begin
`ifdef PERIPH_BUS_ARBITER_LOCK_EN
        lock_d = req_lock[win_q];
        if (!req_lock[win_q])
          rr_ptr_d = (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
`else
        rr_ptr_d = (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      win_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      bad_q     <= 1'b0;
      rdata_q   <= '0;
      data_in_q <= '0;
      ack_q     <= '0;
      err_q     <= '0;
      wen_q     <= '0;
      ren_q     <= '0;
`ifdef PERIPH_BUS_ARBITER_LOCK_EN
      lock_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      win_q     <= win_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      bad_q     <= bad_d;
      rdata_q   <= rdata_d;
      data_in_q <= data_in_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      wen_q     <= wen_d;
      ren_q     <= ren_d;
`ifdef PERIPH_BUS_ARBITER_LOCK_EN
      lock_q    <= lock_d;
`endif
    end
  end

  assign ack           = ack_q;
  assign err           = err_q;
  assign rdata         = rdata_q;
  assign core_data_in  = data_in_q;
  assign core_write_en = wen_q;
  assign core_read_en  = ren_q;

endmodule

`default_nettype wire

// File: tb/tb_periph_bus_arbiter.sv
// tb_periph_bus_arbiter: randomized requesters against a transaction-level reference model
// with a shadow register file. Honours PERIPH_BUS_ARBITER_LOCK_EN when defined. Revision 1.0.
`default_nettype none

module tb_periph_bus_arbiter;

  localparam int NR = 2;
  localparam int RG = 3;
  localparam int AW = 2;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req;
  logic [NR-1:0]     req_we;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR-1:0]     req_lock;
  logic [NR-1:0]     ack;
  logic [NR-1:0]     err;
  logic [DW-1:0]     rdata;
  logic [DW-1:0]     core_data_in;
  logic [RG-1:0]     core_write_en;
  logic [RG-1:0]     core_read_en;
  logic [RG*DW-1:0]  core_data_out;

  always #5 clk = ~clk;

  periph_bus_arbiter #(
    .NUM_REQ      (NR),
    .REGS         (RG),
    .ADDRESSWIDTH (AW),
    .DATAWIDTH    (DW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
`ifdef PERIPH_BUS_ARBITER_LOCK_EN
    .req_lock      (req_lock),
`endif
    .ack           (ack),
    .err           (err),
    .rdata         (rdata),
    .core_data_in  (core_data_in),
    .core_write_en (core_write_en),
    .core_read_en  (core_read_en),
    .core_data_out (core_data_out)
  );

  // Plain register-file core stub.
  logic [DW-1:0] core_regs [RG] = '{default: '0};
  always @(posedge clk)
    for (int r = 0; r < RG; r++)
      if (core_write_en[r]) core_regs[r] <= core_data_in;
  always_comb
    for (int r = 0; r < RG; r++) core_data_out[r*DW +: DW] = core_regs[r];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: one access = arbitrate, strobe cycle, ack cycle.
  int            phase = 0;
  int            ptr   = 0;
  int            w     = 0;
  bit            locked = 1'b0;
  bit            t_we;
  int            t_addr;
  logic [DW-1:0] t_wdata;
  logic [DW-1:0] mem [RG] = '{default: '0};
  logic [NR-1:0] e_ack = '0, e_err = '0;
  logic [RG-1:0] e_wen = '0, e_ren = '0;
  logic [DW-1:0] e_rdata = '0;

  always @(posedge clk) begin
    bit found;
    if (!reset) begin
      // A strobe already issued still writes the core on this edge.
      if (phase == 1 && t_we && t_addr < RG) mem[t_addr] = t_wdata;
      phase = 0; ptr = 0; locked = 1'b0;
      e_ack = '0; e_err = '0; e_wen = '0; e_ren = '0; e_rdata = '0;
    end else begin
      e_ack = '0; e_err = '0; e_wen = '0; e_ren = '0;
      if (phase == 0) begin
        found = 1'b0;
`ifdef PERIPH_BUS_ARBITER_LOCK_EN
        if (locked && req[w] && req_lock[w]) found = 1'b1;
`endif
        locked = 1'b0;
        for (int k = 0; k < NR; k++) begin
          int c;
          c = (ptr + k) % NR;
          if (!found && req[c]) begin found = 1'b1; w = c; end
        end
        if (found) begin
          t_we    = req_we[w];
          t_addr  = int'(req_addr[w*AW +: AW]);
          t_wdata = req_wdata[w*DW +: DW];
          if (t_addr < RG) begin
            if (t_we) e_wen[t_addr] = 1'b1;
            else      e_ren[t_addr] = 1'b1;
          end
          phase = 1;
        end
      end else if (phase == 1) begin
        e_ack[w] = 1'b1;
        e_err[w] = (t_addr >= RG);
        if (t_addr >= RG) e_rdata = '0;
        else if (!t_we)   e_rdata = mem[t_addr];
        else              mem[t_addr] = t_wdata;
        phase = 2;
      end else begin
`ifdef PERIPH_BUS_ARBITER_LOCK_EN
        locked = req_lock[w];
`endif
        if (!locked) ptr = (w + 1) % NR;
        phase = 0;
      end
    end
  end

  task automatic new_txn(input int i);
    req[i]              = 1'b1;
    req_we[i]           = 1'($urandom % 2);
    req_addr[i*AW +: AW] = AW'($urandom_range(0, 3));
    req_wdata[i*DW +: DW] = $urandom;
    req_lock[i]         = ($urandom % 4 == 0);
  endtask

  task automatic check_outputs;
    check_eq("core_write_en", 32'(core_write_en), 32'(e_wen));
    check_eq("core_read_en",  32'(core_read_en),  32'(e_ren));
    check_eq("ack",           32'(ack),           32'(e_ack));
    check_eq("err",           32'(err),           32'(e_err));
    check_eq("rdata",         rdata,              e_rdata);
    if (e_wen != '0) check_eq("core_data_in", core_data_in, t_wdata);
  endtask

  initial begin
    bit keep;
    reset     = 1'b0;
    req       = 2'b11;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_lock  = '0;
    repeat (3) begin
      @(negedge clk);
      check_outputs();
    end
    reset = 1'b1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      check_outputs();
      reset = !(($urandom % 150) == 0);
      keep  = (cyc >= 200 && cyc < 320);
      for (int i = 0; i < NR; i++) begin
        if (ack[i]) begin
          if (keep || ($urandom % 2 == 1)) new_txn(i);
          else begin req[i] = 1'b0; req_lock[i] = 1'b0; end
        end else if (!req[i] && (keep || $urandom % 4 == 0)) begin
          new_txn(i);
        end
      end
    end
    @(negedge clk);
    check_outputs();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
